// File: rtl/hash_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hash_pkg
// Purpose  : Shared widths, FSM states, SHA-256 constants and 1-bit FA cell.
// Revision : 1.0
// ============================================================================
package hash_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        S_ACC = 2'd0,
        S_RES = 2'd1,
        S_OUT = 2'd2
    } state_e;

    localparam logic [WORD_W-1:0] C_SHA_H0 = 32'h6A09E667;
    localparam logic [WORD_W-1:0] C_SHA_H1 = 32'hBB67AE85;

    // Full-adder cell shared by the CSA row and the ripple resolver: {carry, sum}
    function automatic logic [1:0] fa(input logic a, input logic b, input logic c);
        return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
    endfunction

endpackage
`default_nettype wire

// File: rtl/word_sum_accumulator_csa_row.sv
`default_nettype none
// ============================================================================
// Module   : word_sum_accumulator_csa_row
// Purpose  : WIDTH parallel 3:2 compressor cells (unshifted carry vector).
// Revision : 1.0
// ============================================================================
module word_sum_accumulator_csa_row
    import hash_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] c_i,
    output logic [WIDTH-1:0] sum_o,
    output logic [WIDTH-1:0] carry_o
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign {carry_o[i], sum_o[i]} = fa(a_i[i], b_i[i], c_i[i]);
    end

endmodule
`default_nettype wire

// File: rtl/word_sum_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : word_sum_accumulator
// Purpose  : Carry-save multi-operand adder with ripple resolve and
//            valid/ready result port.
// Revision : 1.0
// ============================================================================
module word_sum_accumulator
    import hash_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_overflow,
    output logic [CNT_W-1:0] out_count,
    input  logic             out_ready
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] s_q, s_d, c_q, c_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_ovf_q, out_ovf_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;

    logic [WIDTH-1:0] csa_sum, csa_carry;
    logic [WIDTH-1:0] rip_sum;
    logic [WIDTH:0]   rip_c;

    word_sum_accumulator_csa_row #(.WIDTH(WIDTH)) u_csa (
        .a_i     (s_q),
        .b_i     (c_q),
        .c_i     (in_data),
        .sum_o   (csa_sum),
        .carry_o (csa_carry)
    );

    assign rip_c[0] = 1'b0;
    for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
        assign {rip_c[i+1], rip_sum[i]} = fa(s_q[i], c_q[i], rip_c[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_ACC;
            s_q         <= '0;
            c_q         <= '0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            out_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            c_q         <= c_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
            out_cnt_q   <= out_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        c_d         = c_q;
        ovf_d       = ovf_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        out_cnt_d   = out_cnt_q;
        case (state_q)
            S_ACC: begin
                if (in_valid) begin
                    s_d   = csa_sum;
                    c_d   = {csa_carry[WIDTH-2:0], 1'b0};
                    // The carry shifted out of the MSB is a lost 2^WIDTH term
                    ovf_d = ovf_q | csa_carry[WIDTH-1];
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                    if (in_last) begin
                        state_d = S_RES;
                    end
                end
            end
            S_RES: begin
                out_data_d  = rip_sum;
                out_ovf_d   = ovf_q | rip_c[WIDTH];
                out_cnt_d   = cnt_q;
                out_valid_d = 1'b1;
                s_d         = '0;
                c_d         = '0;
                ovf_d       = 1'b0;
                cnt_d       = '0;
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_ACC;
                end
            end
            default: state_d = S_ACC;
        endcase
    end

    assign in_ready     = (state_q == S_ACC);
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_overflow = out_ovf_q;
    assign out_count    = out_cnt_q;

endmodule
`default_nettype wire
